// File: rtl/uart_rx_word_packer_if.sv
`default_nettype none
// ============================================================================
// uart_rx_word_packer_if : byte-in / word-out bundle for uart_rx_word_packer
// Rev 1.0
// ============================================================================
interface uart_rx_word_packer_if #(
   parameter int DATA_W = 16
);
   localparam int CNT_W = $clog2(DATA_W / 8) + 1;

   logic [2:0]        sel;
   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic              word_ready;
   logic              ovr_clr;
   logic [DATA_W-1:0] word_out;
   logic              word_valid;
   logic [CNT_W-1:0]  byte_cnt;
   logic              timeout;
   logic              overrun;

   modport master (
      input  sel, rx_byte, rx_valid, word_ready, ovr_clr,
      output word_out, word_valid, byte_cnt, timeout, overrun
   );

   modport slave (
      output sel, rx_byte, rx_valid, word_ready, ovr_clr,
      input  word_out, word_valid, byte_cnt, timeout, overrun
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
// uart_rx_word_packer : packs UART bytes into DATA_W words (or bypasses them)
// Rev 1.0
// ============================================================================
module uart_rx_word_packer #(
   parameter int DATA_W      = 16,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   uart_rx_word_packer_if.master  bus
);
   localparam int NBYTES = DATA_W / 8;
   localparam int CNT_W  = $clog2(NBYTES) + 1;
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  C_LAST_CNT = CNT_W'(NBYTES - 1);
   localparam logic [IDLE_W-1:0] C_TO_LAST  = IDLE_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] word_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDLE_W-1:0] idle_q;
   logic [7:0]        skid_q;
   logic              skid_vld_q;
   logic              timeout_q;
   logic              overrun_q;

   logic              w_hold;
   logic              w_take_skid;
   logic              w_take;
   logic              w_drop;
   logic [7:0]        w_byte;
   int                w_lane;
   logic [DATA_W-1:0] w_lane_word;

   // The skid byte always has priority over a fresh strobe outside HOLD.
   assign w_hold      = (state_q == S_HOLD);
   assign w_take_skid = !w_hold && skid_vld_q;
   assign w_take      = !w_hold && (skid_vld_q || bus.rx_valid);
   assign w_drop      = w_hold && bus.rx_valid && skid_vld_q;
   assign w_byte      = w_take_skid ? skid_q : bus.rx_byte;

   always_comb begin
      w_lane      = MSB_FIRST ? (NBYTES - 1 - int'(cnt_q)) : int'(cnt_q);
      w_lane_word = (state_q == S_IDLE) ? '0 : word_q;
      for (int i = 0; i < NBYTES; i++) begin
         if (i == w_lane) begin
            w_lane_word[i*8 +: 8] = w_byte;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         cnt_q      <= '0;
         idle_q     <= '0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         overrun_q <= w_drop || (overrun_q && !bus.ovr_clr);

         if (w_hold) begin
            if (bus.rx_valid && !skid_vld_q) begin
               skid_q     <= bus.rx_byte;
               skid_vld_q <= 1'b1;
            end
         end else if (skid_vld_q) begin
            skid_vld_q <= bus.rx_valid;
            if (bus.rx_valid) begin
               skid_q <= bus.rx_byte;
            end
         end

         // Mode is only sampled here; afterwards the state itself remembers it.
         case (state_q)
            S_IDLE: begin
               idle_q <= '0;
               if (w_take) begin
                  cnt_q <= CNT_W'(1);
                  if (bus.sel == 3'b000) begin
                     word_q  <= DATA_W'(w_byte);
                     state_q <= S_HOLD;
                  end else begin
                     word_q  <= w_lane_word;
                     state_q <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (w_take) begin
                  word_q <= w_lane_word;
                  cnt_q  <= cnt_q + CNT_W'(1);
                  idle_q <= '0;
                  if (cnt_q == C_LAST_CNT) begin
                     state_q <= S_HOLD;
                  end
               end else if (idle_q == C_TO_LAST) begin
                  word_q    <= '0;
                  cnt_q     <= '0;
                  idle_q    <= '0;
                  timeout_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  idle_q <= idle_q + IDLE_W'(1);
               end
            end
            S_HOLD: begin
               if (bus.word_ready) begin
                  word_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.word_out   = word_q;
   assign bus.word_valid = w_hold;
   assign bus.byte_cnt   = cnt_q;
   assign bus.timeout    = timeout_q;
   assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_word_packer : scoreboard bench for three packer configurations
// Rev 1.0
// ============================================================================
module tb_uart_rx_word_packer;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   logic [31:0] mq[$];
   logic [31:0] lq[$];
   logic [31:0] wq[$];

   uart_rx_word_packer_if #(.DATA_W(16)) m_if ();
   uart_rx_word_packer_if #(.DATA_W(16)) l_if ();
   uart_rx_word_packer_if #(.DATA_W(32)) w_if ();

   uart_rx_word_packer #(.DATA_W(16), .MSB_FIRST(1'b1), .TIMEOUT_CYC(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m_if.master)
   );

   uart_rx_word_packer #(.DATA_W(16), .MSB_FIRST(1'b0), .TIMEOUT_CYC(8)) u_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (l_if.master)
   );

   uart_rx_word_packer #(.DATA_W(32), .MSB_FIRST(1'b1), .TIMEOUT_CYC(8)) u_w32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (w_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input logic [7:0] b);
      case (d)
         0:       begin m_if.rx_byte = b; m_if.rx_valid = 1'b1; end
         1:       begin l_if.rx_byte = b; l_if.rx_valid = 1'b1; end
         default: begin w_if.rx_byte = b; w_if.rx_valid = 1'b1; end
      endcase
      tick();
      m_if.rx_valid = 1'b0;
      l_if.rx_valid = 1'b0;
      w_if.rx_valid = 1'b0;
   endtask

   // Scoreboards: a word is checked on the cycle it is transferred.
   always @(negedge clk) begin
      if (rst_n && m_if.word_valid && m_if.word_ready) begin
         if (mq.size() == 0) chk("m_unexpected_word", mq.size(), 1);
         else                chk("m_word", 32'(m_if.word_out), mq.pop_front());
      end
      if (rst_n && l_if.word_valid && l_if.word_ready) begin
         if (lq.size() == 0) chk("l_unexpected_word", lq.size(), 1);
         else                chk("l_word", 32'(l_if.word_out), lq.pop_front());
      end
      if (rst_n && w_if.word_valid && w_if.word_ready) begin
         if (wq.size() == 0) chk("w_unexpected_word", wq.size(), 1);
         else                chk("w_word", w_if.word_out, wq.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      m_if.sel = 3'b000; m_if.rx_byte = '0; m_if.rx_valid = 1'b0;
      m_if.word_ready = 1'b1; m_if.ovr_clr = 1'b0;
      l_if.sel = 3'b001; l_if.rx_byte = '0; l_if.rx_valid = 1'b0;
      l_if.word_ready = 1'b1; l_if.ovr_clr = 1'b0;
      w_if.sel = 3'b001; w_if.rx_byte = '0; w_if.rx_valid = 1'b0;
      w_if.word_ready = 1'b1; w_if.ovr_clr = 1'b0;
      repeat (3) tick();
      chk("rst_word_out", 32'(m_if.word_out), 0);
      chk("rst_word_valid", 32'(m_if.word_valid), 0);
      chk("rst_byte_cnt", 32'(m_if.byte_cnt), 0);
      chk("rst_timeout", 32'(m_if.timeout), 0);
      chk("rst_overrun", 32'(m_if.overrun), 0);
      rst_n = 1'b1;
      tick();

      // Bypass: one byte, one-cycle valid with ready high
      m_if.sel = 3'b000;
      mq.push_back(32'h0000_00A5);
      send(0, 8'hA5);
      chk("byp_valid_next_cycle", 32'(m_if.word_valid), 1);
      tick();
      chk("byp_valid_one_cycle", 32'(m_if.word_valid), 0);

      // Pack, MSB first, LSB first, and 32-bit
      m_if.sel = 3'b001;
      mq.push_back(32'h0000_1234);
      send(0, 8'h12);
      chk("pack_cnt_1", 32'(m_if.byte_cnt), 1);
      send(0, 8'h34);
      chk("pack_valid", 32'(m_if.word_valid), 1);
      tick();
      lq.push_back(32'h0000_3412);
      send(1, 8'h12);
      send(1, 8'h34);
      tick();
      wq.push_back(32'h0102_0304);
      for (int i = 1; i <= 4; i++) send(2, 8'(i));
      tick();

      // Backpressure: skid holds 0x56, 0x78 is dropped
      m_if.word_ready = 1'b0;
      mq.push_back(32'h0000_1234);
      send(0, 8'h12);
      send(0, 8'h34);
      send(0, 8'h56);
      send(0, 8'h78);
      chk("bp_overrun_set", 32'(m_if.overrun), 1);
      chk("bp_word_held", 32'(m_if.word_out), 32'h1234);
      chk("bp_valid_held", 32'(m_if.word_valid), 1);
      m_if.word_ready = 1'b1;
      mq.push_back(32'h0000_569A);
      tick();
      tick();
      chk("bp_skid_cnt", 32'(m_if.byte_cnt), 1);
      m_if.ovr_clr = 1'b1;
      tick();
      m_if.ovr_clr = 1'b0;
      chk("bp_overrun_clr", 32'(m_if.overrun), 0);
      send(0, 8'h9A);
      tick();

      // Timeout after 8 idle cycles
      send(0, 8'hEE);
      repeat (7) tick();
      chk("to_not_yet", 32'(m_if.timeout), 0);
      chk("to_cnt_before", 32'(m_if.byte_cnt), 1);
      tick();
      chk("to_pulse", 32'(m_if.timeout), 1);
      chk("to_cnt_cleared", 32'(m_if.byte_cnt), 0);
      chk("to_no_valid", 32'(m_if.word_valid), 0);
      tick();
      chk("to_pulse_width", 32'(m_if.timeout), 0);
      mq.push_back(32'h0000_1122);
      send(0, 8'h11);
      send(0, 8'h22);
      tick();

      // Mode change mid-word is deferred
      m_if.sel = 3'b001;
      mq.push_back(32'h0000_ABCD);
      send(0, 8'hAB);
      m_if.sel = 3'b000;
      send(0, 8'hCD);
      tick();
      mq.push_back(32'h0000_00EF);
      send(0, 8'hEF);
      tick();

      // Reset with a partial word and a full skid buffer
      m_if.sel = 3'b001;
      m_if.word_ready = 1'b0;
      mq.push_back(32'h0000_1234);
      send(0, 8'h12);
      send(0, 8'h34);
      send(0, 8'h56);
      m_if.word_ready = 1'b1;
      tick();
      send(0, 8'h77);
      chk("rst_pre_cnt", 32'(m_if.byte_cnt), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_word_out", 32'(m_if.word_out), 0);
      chk("mid_rst_valid", 32'(m_if.word_valid), 0);
      chk("mid_rst_cnt", 32'(m_if.byte_cnt), 0);
      chk("mid_rst_timeout", 32'(m_if.timeout), 0);
      chk("mid_rst_overrun", 32'(m_if.overrun), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      mq.push_back(32'h0000_0102);
      send(0, 8'h01);
      send(0, 8'h02);
      repeat (3) tick();

      chk("m_queue_drained", mq.size(), 0);
      chk("l_queue_drained", lq.size(), 0);
      chk("w_queue_drained", wq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
